// File: rtl/ladybird_uart_loader_if.sv
// rtl/ladybird_uart_loader_if.sv - byte-in, byte-out, memory bus and jump signals of the UART loader
interface ladybird_uart_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        jump_valid;
  logic [31:0] jump_pc;

  modport master (
    input  in_valid, in_data, out_ready, mem_ready, mem_rvalid, mem_rdata,
    output in_ready, out_valid, out_data, mem_valid, mem_we, mem_addr, mem_wdata,
           jump_valid, jump_pc
  );

  modport slave (
    output in_valid, in_data, out_ready, mem_ready, mem_rvalid, mem_rdata,
    input  in_ready, out_valid, out_data, mem_valid, mem_we, mem_addr, mem_wdata,
           jump_valid, jump_pc
  );
endinterface

// File: rtl/ladybird_uart_loader.sv
// rtl/ladybird_uart_loader.sv - UART command parser issuing W/R/J packets as 32-bit bus transactions
// Optional 'K' acknowledge after writes and jumps: define LADYBIRD_UART_LOADER_ACK_EN.
module ladybird_uart_loader #(
  parameter int unsigned TIMEOUT = 32'h00FF_FFFF
) (
  input  logic                     clk,
  input  logic                     rst,
  ladybird_uart_loader_if.master   bus
);

  localparam logic [7:0]  CMD_W   = 8'h57;
  localparam logic [7:0]  CMD_R   = 8'h52;
  localparam logic [7:0]  CMD_J   = 8'h4A;
`ifdef LADYBIRD_UART_LOADER_ACK_EN
  localparam logic [7:0]  ACK_BYTE = 8'h4B;
`endif
  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, BUS_REQ, BUS_WAIT, RESP
`ifdef LADYBIRD_UART_LOADER_ACK_EN
    , ACK
`endif
  } state_t;

  state_t      state_q;
  logic [7:0]  cmd_q;
  logic [1:0]  idx_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [31:0] timer_q;
  logic [7:0]  error_cnt_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [7:0]  out_data_q;
  logic        mem_valid_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        jump_valid_q;
  logic [31:0] jump_pc_q;

  logic        in_hs;
  logic        out_hs;
  logic        mem_hs;
  logic [31:0] addr_d;
  logic [31:0] wdata_d;
  logic [7:0]  error_cnt_d;

  assign in_hs  = bus.in_valid & in_ready_q;
  assign out_hs = out_valid_q & bus.out_ready;
  assign mem_hs = mem_valid_q & bus.mem_ready;

  // Fields arrive LSB first, so each byte enters at the top and shifts down.
  assign addr_d      = {bus.in_data, addr_q[31:8]};
  assign wdata_d     = {bus.in_data, wdata_q[31:8]};
  assign error_cnt_d = (error_cnt_q == 8'hFF) ? 8'hFF : error_cnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cmd_q        <= 8'h00;
      idx_q        <= 2'd0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      rdata_q      <= 32'h0;
      timer_q      <= 32'h0;
      error_cnt_q  <= 8'h00;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      jump_valid_q <= 1'b0;
      jump_pc_q    <= 32'h0;
    end else begin
      jump_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_hs) begin
            if (bus.in_data == CMD_W || bus.in_data == CMD_R || bus.in_data == CMD_J) begin
              cmd_q   <= bus.in_data;
              idx_q   <= 2'd0;
              timer_q <= 32'h0;
              state_q <= ADDR;
            end else begin
              error_cnt_q <= error_cnt_d;
            end
          end
        end

        ADDR, DATA: begin
          if (in_hs) begin
            timer_q <= 32'h0;
            idx_q   <= idx_q + 2'd1;
            if (state_q == ADDR) addr_q <= addr_d;
            else                 wdata_q <= wdata_d;
            if (idx_q == 2'd3) begin
              if (state_q == DATA) begin
                in_ready_q  <= 1'b0;
                mem_valid_q <= 1'b1;
                mem_we_q    <= 1'b1;
                mem_addr_q  <= {addr_q[31:2], 2'b00};
                mem_wdata_q <= wdata_d;
                state_q     <= BUS_REQ;
              end else if (cmd_q == CMD_W) begin
                state_q <= DATA;
              end else if (cmd_q == CMD_R) begin
                in_ready_q  <= 1'b0;
                mem_valid_q <= 1'b1;
                mem_we_q    <= 1'b0;
                mem_addr_q  <= {addr_d[31:2], 2'b00};
                state_q     <= BUS_REQ;
              end else begin
                jump_valid_q <= 1'b1;
                jump_pc_q    <= addr_d;
`ifdef LADYBIRD_UART_LOADER_ACK_EN
                in_ready_q   <= 1'b0;
                out_valid_q  <= 1'b1;
                out_data_q   <= ACK_BYTE;
                state_q      <= ACK;
`else
                state_q      <= IDLE;
`endif
              end
            end
          end else if (TO_EN && timer_q == TO_LAST) begin
            // Sender went quiet mid-packet: drop what we have and resync on the next command byte.
            timer_q     <= 32'h0;
            error_cnt_q <= error_cnt_d;
            state_q     <= IDLE;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end

        BUS_REQ: begin
          if (mem_hs) begin
            mem_valid_q <= 1'b0;
            if (mem_we_q) begin
`ifdef LADYBIRD_UART_LOADER_ACK_EN
              out_valid_q <= 1'b1;
              out_data_q  <= ACK_BYTE;
              state_q     <= ACK;
`else
              in_ready_q  <= 1'b1;
              state_q     <= IDLE;
`endif
            end else if (bus.mem_rvalid) begin
              rdata_q     <= bus.mem_rdata;
              out_valid_q <= 1'b1;
              out_data_q  <= bus.mem_rdata[7:0];
              idx_q       <= 2'd0;
              state_q     <= RESP;
            end else begin
              state_q <= BUS_WAIT;
            end
          end
        end

        BUS_WAIT: begin
          if (bus.mem_rvalid) begin
            rdata_q     <= bus.mem_rdata;
            out_valid_q <= 1'b1;
            out_data_q  <= bus.mem_rdata[7:0];
            idx_q       <= 2'd0;
            state_q     <= RESP;
          end
        end

        RESP: begin
          if (out_hs) begin
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= IDLE;
            end else begin
              out_data_q <= rdata_q[15:8];
              rdata_q    <= {8'h00, rdata_q[31:8]};
            end
          end
        end

`ifdef LADYBIRD_UART_LOADER_ACK_EN
        ACK: begin
          if (out_hs) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
`endif

        default: begin
          in_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.mem_valid  = mem_valid_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.jump_valid = jump_valid_q;
  assign bus.jump_pc    = jump_pc_q;

endmodule

// File: tb/tb_ladybird_uart_loader.sv
// tb/tb_ladybird_uart_loader.sv - scoreboard bench for ladybird_uart_loader (TIMEOUT=16)
module tb_ladybird_uart_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ladybird_uart_loader_if bus ();
  ladybird_uart_loader #(.TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  logic [7:0]  exp_out_q [$];
  mem_req_t    exp_mem_q [$];
  logic [31:0] exp_jump = 32'h0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          jump_pulses = 0;
  logic        stall_seen = 1'b0;
  logic [7:0]  stall_data = 8'h00;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response byte scoreboard plus hold check while the transmitter stalls.
  always @(negedge clk) begin
    if (rst) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        check("out_hold_valid", 64'(bus.out_valid), 64'd1);
        check("out_hold_data", 64'(bus.out_data), 64'(stall_data));
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        check("out_pending", 64'(exp_out_q.size() != 0), 64'd1);
        if (exp_out_q.size() != 0) check("out_byte", 64'(bus.out_data), 64'(exp_out_q.pop_front()));
      end
      stall_seen = (bus.out_valid === 1'b1 && bus.out_ready === 1'b0);
      stall_data = bus.out_data;
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.mem_valid === 1'b1 && bus.mem_ready === 1'b1) begin
      mem_req_t e;
      check("mem_pending", 64'(exp_mem_q.size() != 0), 64'd1);
      if (exp_mem_q.size() != 0) begin
        e = exp_mem_q.pop_front();
        check("mem_we", 64'(bus.mem_we), 64'(e.we));
        check("mem_addr", 64'(bus.mem_addr), 64'(e.addr));
        if (e.we) check("mem_wdata", 64'(bus.mem_wdata), 64'(e.wdata));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.jump_valid === 1'b1) begin
      jump_pulses++;
      check("jump_pc_pulse", 64'(bus.jump_pc), 64'(exp_jump));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int budget = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    forever begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) break;
      budget++;
      if (budget > 200) begin
        check("in_ready_wait", 64'(bus.in_ready), 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] cmd, input logic [31:0] a);
    logic [31:0] v = a;
    send_byte(cmd);
    for (int i = 0; i < 4; i++) begin
      send_byte(v[7:0]);
      v = v >> 8;
    end
  endtask

  task automatic send_word(input logic [31:0] d);
    logic [31:0] v = d;
    for (int i = 0; i < 4; i++) begin
      send_byte(v[7:0]);
      v = v >> 8;
    end
  endtask

  task automatic push_word_out(input logic [31:0] d);
    logic [31:0] v = d;
    for (int i = 0; i < 4; i++) begin
      exp_out_q.push_back(v[7:0]);
      v = v >> 8;
    end
  endtask

  task automatic push_ack();
`ifdef LADYBIRD_UART_LOADER_ACK_EN
    exp_out_q.push_back(8'h4B);
`endif
  endtask

  task automatic drain(input string tag);
    int b = 0;
    while ((exp_out_q.size() != 0 || exp_mem_q.size() != 0) && b < 500) begin
      wait_cycles(1);
      b++;
    end
    check(tag, 64'(exp_out_q.size() + exp_mem_q.size()), 64'd0);
  endtask

  initial begin
    logic [2:0] st;
    bus.in_valid   = 1'b0;
    bus.in_data    = 8'h00;
    bus.out_ready  = 1'b1;
    bus.mem_ready  = 1'b1;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;

    // Reset values
    wait_cycles(2);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    check("rst_jump", 64'({bus.jump_valid, bus.jump_pc}), 64'd0);
    check("rst_error_cnt", 64'(dut.error_cnt_q), 64'd0);
    rst = 1'b0;
    wait_cycles(1);
    check("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

    // Write, mem_ready tied high, minimum latency
    exp_mem_q.push_back('{we: 1'b1, addr: 32'h8000_0010, wdata: 32'hDEAD_BEEF});
    push_ack();
    send_pkt(8'h57, 32'h8000_0010);
    send_word(32'hDEAD_BEEF);
    check("w_latency", 64'(bus.mem_valid), 64'd1);
    wait_cycles(1);
    check("w_single_cycle", 64'(bus.mem_valid), 64'd0);
    drain("w_drain");

    // Read, rvalid 3 cycles after request, transmitter stall mid-stream
    exp_mem_q.push_back('{we: 1'b0, addr: 32'h8000_0100, wdata: 32'h0});
    push_word_out(32'h1234_5678);
    send_pkt(8'h52, 32'h8000_0100);
    wait_cycles(3);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1234_5678;
    wait_cycles(1);
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    wait_cycles(1);
    bus.out_ready = 1'b0;
    wait_cycles(5);
    bus.out_ready = 1'b1;
    drain("r_drain");

    // Read with rvalid in the handshake cycle, unaligned address
    exp_mem_q.push_back('{we: 1'b0, addr: 32'h0000_0040, wdata: 32'h0});
    push_word_out(32'hA5C3_0F81);
    send_pkt(8'h52, 32'h0000_0041);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hA5C3_0F81;
    wait_cycles(1);
    bus.mem_rvalid = 1'b0;
    check("r_skip_wait", 64'(bus.out_valid), 64'd1);
    drain("r2_drain");

    // Jump
    exp_jump = 32'h8000_0000;
    push_ack();
    send_pkt(8'h4A, 32'h8000_0000);
    wait_cycles(5);
    check("jump_pulses", 64'(jump_pulses), 64'd1);
    check("jump_valid_low", 64'(bus.jump_valid), 64'd0);
    check("jump_pc_held", 64'(bus.jump_pc), 64'h8000_0000);
    drain("j_drain");

    // Garbage then write with bus back-pressure
    send_byte(8'h00);
    send_byte(8'hFF);
    check("garbage_error_cnt", 64'(dut.error_cnt_q), 64'd2);
    bus.mem_ready = 1'b0;
    exp_mem_q.push_back('{we: 1'b1, addr: 32'h0000_0200, wdata: 32'h0BAD_F00D});
    push_ack();
    send_pkt(8'h57, 32'h0000_0200);
    send_word(32'h0BAD_F00D);
    wait_cycles(3);
    check("bp_mem_valid", 64'(bus.mem_valid), 64'd1);
    check("bp_mem_addr", 64'(bus.mem_addr), 64'h0000_0200);
    check("bp_mem_wdata", 64'(bus.mem_wdata), 64'h0BAD_F00D);
    bus.mem_ready = 1'b1;
    drain("bp_drain");

    // Inter-byte timeout, then a normal read
    send_byte(8'h57);
    send_byte(8'h10);
    send_byte(8'h00);
    wait_cycles(16);
    st = dut.state_q;
    check("timeout_state_idle", 64'(st), 64'd0);
    check("timeout_error_cnt", 64'(dut.error_cnt_q), 64'd3);
    wait_cycles(4);
    exp_mem_q.push_back('{we: 1'b0, addr: 32'h8000_0020, wdata: 32'h0});
    push_word_out(32'hCAFE_F00D);
    send_pkt(8'h52, 32'h8000_0020);
    wait_cycles(1);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFE_F00D;
    wait_cycles(1);
    bus.mem_rvalid = 1'b0;
    drain("to_drain");

    // Reset while waiting for read data
    exp_mem_q.push_back('{we: 1'b0, addr: 32'h0000_0300, wdata: 32'h0});
    send_pkt(8'h52, 32'h0000_0300);
    wait_cycles(2);
    rst = 1'b1;
    wait_cycles(1);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_mem", 64'({bus.mem_valid, bus.mem_addr}), 64'd0);
    check("mid_rst_jump_pc", 64'(bus.jump_pc), 64'd0);
    check("mid_rst_error_cnt", 64'(dut.error_cnt_q), 64'd0);
    rst = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hFFFF_FFFF;
    wait_cycles(1);
    bus.mem_rvalid = 1'b0;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    wait_cycles(5);
    check("late_rvalid_ignored", 64'(bus.out_valid), 64'd0);
    exp_mem_q.push_back('{we: 1'b1, addr: 32'h0000_0010, wdata: 32'h0102_0304});
    push_ack();
    send_pkt(8'h57, 32'h0000_0010);
    send_word(32'h0102_0304);
    drain("post_rst_drain");

    wait_cycles(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ladybird_uart_loader.md
Name: ladybird_uart_loader

Overview:
- Command parser directly downstream of the UART receiver; consumes its valid/ready byte stream.
- Assembles write, read and jump packets and issues single 32-bit memory bus transactions.
- Read data and optional acks go back as a byte stream toward the UART transmitter.
- Used for program loading and debug poke/peek before core start.

Parameters:
TIMEOUT, 32'h00FF_FFFF, max idle cycles between bytes inside a packet before abort; 0 disables timeout.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  byte from receiver valid
in_data  in  8  received byte
in_ready  out  1  loader accepts byte
out_valid  out  1  response byte valid
out_data  out  8  response byte
out_ready  in  1  transmitter accepts response byte
mem_valid  out  1  bus request valid
mem_ready  in  1  bus accepts request
mem_we  out  1  1 = write, 0 = read
mem_addr  out  32  word address (bits [1:0] forced 0)
mem_wdata  out  32  write data
mem_rvalid  in  1  read data valid (one outstanding read max)
mem_rdata  in  32  read data
jump_valid  out  1  one-cycle pulse: start core
jump_pc  out  32  start PC, held until next jump

Behaviour:
- Byte transfer on in_valid & in_ready; response byte transfer on out_valid & out_ready; bus request on mem_valid & mem_ready.
- Packets, multi-byte fields little-endian:
  - 'W' (0x57) + 4 addr + 4 data
  - 'R' (0x52) + 4 addr
  - 'J' (0x4A) + 4 addr
- Any other byte in IDLE is consumed and discarded; error_cnt (internal, 8 bit, saturating at 0xFF) increments.
- States: IDLE, ADDR, DATA, BUS_REQ, BUS_WAIT, RESP, ACK.
  - IDLE: accept command; go to ADDR, byte index 0.
  - ADDR: shift in 4 bytes. After the 4th: W -> DATA; R -> BUS_REQ; J -> pulse jump_valid next cycle, load jump_pc, then IDLE (or ACK).
  - DATA: 4 bytes, then BUS_REQ.
  - BUS_REQ: mem_valid held with stable addr/we/wdata until mem_ready. W -> IDLE (or ACK); R -> BUS_WAIT.
  - BUS_WAIT: capture mem_rdata on mem_rvalid; go to RESP. mem_rvalid arriving in the same cycle as the mem_ready handshake is captured directly and skips BUS_WAIT.
  - RESP: emit 4 bytes LSB first; out_data/out_valid held stable until out_ready; then IDLE.
- in_ready = 1 only in IDLE, ADDR, DATA. Bytes arriving in other states are back-pressured, never dropped.
- Inter-byte timer counts cycles in ADDR/DATA without a byte handshake; reset on each handshake. Reaching TIMEOUT: discard packet, return to IDLE, increment error_cnt. Timer inactive when TIMEOUT = 0.
- Byte index wraps 3 -> 0 on field completion only.
- Reset values: in_ready 0 in the reset cycle, 1 in the first cycle after reset. out_valid, mem_valid, mem_we, jump_valid 0; out_data 8'h00; mem_addr, mem_wdata, jump_pc 32'h0; error_cnt 0; state IDLE.
- Reset mid-packet or mid-bus-transaction abandons it; a late mem_rvalid after reset is ignored.
- Minimum latency: last data byte accepted -> mem_valid high the next cycle.

Optional Feature:
- Macro LADYBIRD_UART_LOADER_ACK_EN.
- Defined: after a completed W bus handshake or J pulse, enter ACK and emit one byte 0x4B ('K') with normal out handshake, then IDLE.
- Not defined: ACK state absent; W and J produce no output bytes; R unaffected.

Test Plan:
- Bytes 57 10 00 00 80 EF BE AD DE, mem_ready tied 1 -> one cycle of mem_valid=1, mem_we=1, mem_addr=0x8000_0010, mem_wdata=0xDEAD_BEEF; with ACK_EN, one out byte 0x4B.
- 52 00 01 00 80, mem_rvalid 3 cycles after request with rdata 0x1234_5678 -> out bytes 78 56 34 12; out_ready low 5 cycles mid-stream holds byte stable, no loss.
- 4A 00 00 00 80 -> single-cycle jump_valid, jump_pc=0x8000_0000 held afterward.
- Garbage 0x00, 0xFF, then a valid W packet -> garbage ignored, error_cnt=2, write issues normally.
- TIMEOUT=16: 57 10 00, then 20 idle cycles, then a full R packet -> no W issued, FSM back to IDLE by cycle 16, R executes correctly.
- rst asserted during BUS_WAIT, then mem_rvalid pulses -> no out_valid; outputs at reset values; next packet works.
